// File: rtl/quiz_pkg.sv
// Shared types and helpers for the N-team quiz controller.
package quiz_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ANSWER,
        S_JUDGE,
        S_HOLD,
        S_SCAN,
        S_FINAL
    } state_t;

    localparam logic [15:0] ONE_HOT_NONE = 16'h0000;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/quiz_tick_gen.sv
// Seconds prescaler: pulses tick every CLKS_PER_TICK cycles while run is high.
// Held at zero when idle so each timed window starts with a full second.
module quiz_tick_gen
    import quiz_pkg::*;
#(
    parameter int CLKS_PER_TICK = 5_000_000
) (
    input  logic clk,
    input  logic master_reset,
    input  logic run,
    input  logic restart,
    output logic tick
);
    localparam int PW = (clog2(CLKS_PER_TICK) > 0) ? clog2(CLKS_PER_TICK) : 1;
    localparam logic [PW-1:0] LAST = PW'(CLKS_PER_TICK - 1);

    logic [PW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (master_reset || !run || restart) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + PW'(1);
        end
    end

    assign tick = run && (cnt == LAST);

endmodule

// File: rtl/quiz_controller_n.sv
// N-team quiz controller: buzzer arbitration with wrong-answer lockout, answer/judge
// countdowns, saturating score bank and a one-team-per-cycle winner scan.
module quiz_controller_n
    import quiz_pkg::*;
#(
    parameter int N_TEAMS       = 4,
    parameter int SCORE_W       = 4,
    parameter int CLKS_PER_TICK = 5_000_000,
    parameter int ANSWER_SECS   = 10,
    parameter int JUDGE_SECS    = 5,
    parameter int CNT_W         = 4
) (
    input  logic                       clk,
    input  logic                       master_reset,
    input  logic                       reset,
    input  logic [N_TEAMS-1:0]         buzz,
    input  logic                       correct,
    input  logic                       wrong,
    input  logic                       auto_mode,
    input  logic                       end_quiz,
    input  logic [clog2(N_TEAMS)-1:0]  score_sel,
    output logic [N_TEAMS-1:0]         active_team,
    output logic                       buzzer_locked,
    output logic                       timeup,
    output logic                       judging_time,
    output logic [CNT_W-1:0]           countdown,
    output logic [SCORE_W-1:0]         score_rd,
    output logic [N_TEAMS-1:0]         winner_team,
    output logic                       winner_valid,
    output logic                       tie
);
    localparam int SEL_W = clog2(N_TEAMS);

    state_t               state, state_next;
    logic [N_TEAMS-1:0]   act_q, lockout_q, eligible, grant, lock_wrong;
    logic [CNT_W-1:0]     cd_q;
    logic [SCORE_W-1:0]   scores [N_TEAMS];
    logic [SEL_W-1:0]     scan_idx, top_q, top_n;
    logic [SCORE_W-1:0]   max_q, max_n, cur_score;
    logic                 tie_q, tie_n;
    logic                 on_floor, run, tick, abort, scan_last;

    assign on_floor   = (state == S_ANSWER) || (state == S_JUDGE) || (state == S_HOLD);
    assign run        = (state == S_ANSWER) || (state == S_JUDGE);
    assign abort      = (end_quiz || reset) && (state != S_FINAL);
    assign eligible   = buzz & ~lockout_q;
    assign grant      = eligible & (~eligible + N_TEAMS'(1));
    // A wrong answer that would lock every team kills the question and reopens all buzzers.
    assign lock_wrong = ((lockout_q | act_q) == '1) ? '0 : (lockout_q | act_q);
    assign scan_last  = (scan_idx == SEL_W'(N_TEAMS - 1));
    assign cur_score  = scores[scan_idx];
    assign score_rd   = (int'(score_sel) < N_TEAMS) ? scores[score_sel] : '0;

    quiz_tick_gen #(.CLKS_PER_TICK(CLKS_PER_TICK)) u_tick (
        .clk          (clk),
        .master_reset (master_reset),
        .run          (run),
        .restart      (state_next != state),
        .tick         (tick)
    );

    always_ff @(posedge clk) begin
        if (master_reset) state <= S_IDLE;
        else              state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (end_quiz && state != S_FINAL) begin
            state_next = S_SCAN;
        end else if (reset && state != S_FINAL) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE:   if (|eligible) state_next = S_ANSWER;
                S_ANSWER: if (correct || wrong) state_next = S_IDLE;
                          else if (tick && cd_q <= CNT_W'(1)) state_next = S_JUDGE;
                S_JUDGE:  if (correct || wrong) state_next = S_IDLE;
                          else if (tick && cd_q <= CNT_W'(1)) state_next = auto_mode ? S_IDLE : S_HOLD;
                S_HOLD:   if (correct || wrong) state_next = S_IDLE;
                S_SCAN:   if (scan_last) state_next = S_FINAL;
                default:  state_next = state;
            endcase
        end
    end

    // Running maximum; the first team seeds it so an all-zero board still reports a tie.
    always_comb begin
        max_n = max_q;
        tie_n = tie_q;
        top_n = top_q;
        if (scan_idx == '0 || cur_score > max_q) begin
            max_n = cur_score;
            tie_n = 1'b0;
            top_n = scan_idx;
        end else if (cur_score == max_q) begin
            tie_n = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (master_reset) begin
            act_q     <= '0;
            lockout_q <= '0;
            cd_q      <= '0;
            scan_idx  <= '0;
            max_q     <= '0;
            top_q     <= '0;
            tie_q     <= 1'b0;
            for (int i = 0; i < N_TEAMS; i++) scores[i] <= '0;
        end else if (abort) begin
            act_q     <= '0;
            lockout_q <= '0;
            cd_q      <= '0;
            scan_idx  <= '0;
        end else if (on_floor && correct) begin
            for (int i = 0; i < N_TEAMS; i++) begin
                if (act_q[i] && scores[i] != '1) scores[i] <= scores[i] + SCORE_W'(1);
            end
            lockout_q <= '0;
            act_q     <= '0;
            cd_q      <= '0;
        end else if (on_floor && wrong) begin
            lockout_q <= lock_wrong;
            act_q     <= '0;
            cd_q      <= '0;
        end else if (tick) begin
            if (cd_q > CNT_W'(1)) begin
                cd_q <= cd_q - CNT_W'(1);
            end else if (state == S_ANSWER) begin
                cd_q <= CNT_W'(JUDGE_SECS);
            end else begin
                cd_q <= '0;
                if (auto_mode) begin
                    lockout_q <= '0;
                    act_q     <= '0;
                end
            end
        end else if (state == S_IDLE && |eligible) begin
            act_q <= grant;
            cd_q  <= CNT_W'(ANSWER_SECS);
        end else if (state == S_SCAN) begin
            scan_idx <= scan_idx + SEL_W'(1);
            max_q    <= max_n;
            tie_q    <= tie_n;
            top_q    <= top_n;
        end
    end

    always_comb begin
        active_team   = act_q;
        buzzer_locked = on_floor;
        timeup        = (state == S_JUDGE) || (state == S_HOLD);
        judging_time  = (state == S_JUDGE);
        countdown     = '0;
        winner_valid  = (state == S_FINAL);
        tie           = (state == S_FINAL) && tie_q;
        winner_team   = ONE_HOT_NONE[N_TEAMS-1:0];
        if (run) countdown = cd_q;
        if (state == S_FINAL) begin
            countdown = CNT_W'(max_q);
            if (!tie_q) winner_team = N_TEAMS'(1) << top_q;
        end
    end

endmodule
